// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//
// Purpose:
//   An 8-bit ALU with eight operations: ADD, LSH, RSH, XOR, AND, SUB, OR and
//   RXR (reduction XOR). Out, Zero and SC_out are purely combinational from the
//   operand and opcode inputs. Clk and Reset only affect the optional flag
//   register Flags_q.
//
// Configuration:
//   ALU_FLAG_REG_EN
//     - Defined: Flags_q registers {SC_out, Zero} on every rising Clk.
//       A synchronous Reset clears it to 2'b00, and Reset takes priority
//       over the capture.
//     - Undefined (default): no flip-flops are built and Flags_q is tied
//       to 2'b00.
//
// Ports:
//   Clk     in   1   clock; Flags_q updates on the rising edge
//   Reset   in   1   synchronous active-high reset, affects only Flags_q
//   InputA  in   8   operand A
//   InputB  in   8   operand B
//   SC_in   in   1   shift-in / carry-in
//   OP      in   3   operation select:
//                      000 ADD, 001 LSH, 010 RSH, 011 XOR,
//                      100 AND, 101 SUB, 110 OR,  111 RXR
//   Out     out  8   result (combinational)
//   Zero    out  1   1 when Out == 0 (combinational)
//   SC_out  out  1   carry / borrow / shifted-out bit (combinational)
//   Flags_q out  2   registered {SC_out, Zero}: bit1 = carry, bit0 = zero
// -----------------------------------------------------------------------------
module alu (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] InputA,
    input  logic [7:0] InputB,
    input  logic       SC_in,
    input  logic [2:0] OP,
    output logic [7:0] Out,
    output logic       Zero,
    output logic       SC_out,
    output logic [1:0] Flags_q
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_LSH = 3'b001,
        OP_RSH = 3'b010,
        OP_XOR = 3'b011,
        OP_AND = 3'b100,
        OP_SUB = 3'b101,
        OP_OR  = 3'b110,
        OP_RXR = 3'b111
    } alu_op_e;

    // Nine-bit add and subtract.
    // Bit 8 of the add result is the carry out. Bit 8 of the subtract result
    // is the borrow, which is set exactly when A < B (unsigned).
    logic [8:0] sum_9;
    logic [8:0] diff_9;

    assign sum_9  = {1'b0, InputA} + {1'b0, InputB} + {8'b0, SC_in};
    assign diff_9 = {1'b0, InputA} - {1'b0, InputB};

    // Result and carry selection.
    // Every branch assigns both outputs after the defaults, so Out never
    // becomes X for any 2-state input combination.
    always_comb begin
        Out    = 8'h00;
        SC_out = 1'b0;
        case (alu_op_e'(OP))
            OP_ADD: begin
                Out    = sum_9[7:0];
                SC_out = sum_9[8];
            end
            OP_LSH: begin
                Out    = {InputA[6:0], SC_in};
                SC_out = InputA[7];
            end
            OP_RSH: begin
                Out    = {1'b0, InputA[7:1]};
                SC_out = InputA[0];
            end
            OP_XOR: begin
                Out    = InputA ^ InputB;
                SC_out = 1'b0;
            end
            OP_AND: begin
                Out    = InputA & InputB;
                SC_out = 1'b0;
            end
            OP_SUB: begin
                Out    = diff_9[7:0];
                SC_out = diff_9[8];
            end
            OP_OR: begin
                Out    = InputA | InputB;
                SC_out = 1'b0;
            end
            OP_RXR: begin
                Out    = {7'b0, ^InputA};
                SC_out = 1'b0;
            end
            default: begin
                Out    = 8'h00;
                SC_out = 1'b0;
            end
        endcase
    end

    // Zero always follows the final result, including for shifts and RXR.
    assign Zero = (Out == 8'h00);

`ifdef ALU_FLAG_REG_EN
    logic [1:0] flags_d;

    assign flags_d = {SC_out, Zero};

    // Flag register. Reset is checked first, so it wins over a capture on
    // the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Flags_q <= 2'b00;
        end else begin
            Flags_q <= flags_d;
        end
    end
`else
    // Without the flag register the clock and reset have no load.
    logic unused_clk_reset;

    assign unused_clk_reset = Clk ^ Reset;
    assign Flags_q          = 2'b00;
`endif

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//
// Self-checking bench for alu.
//
// The reference model computes each result from the operation definitions
// using plain integer arithmetic. One compare process runs on the falling
// edge of Clk and checks the DUT outputs on every cycle against:
//   - the reference model, and
//   - optional hand-computed literals that come with each directed stimulus.
//
// Flags_q is expected to follow {SC_out, Zero} from the previous rising edge
// when ALU_FLAG_REG_EN is defined, and to be 2'b00 otherwise.
// -----------------------------------------------------------------------------
module tb_alu;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       SC_in;
    logic [2:0] OP;
    logic [7:0] Out;
    logic       Zero;
    logic       SC_out;
    logic [1:0] Flags_q;

    int checks = 0;
    int errors = 0;

    // Literal expectations that come with the current stimulus.
    //   litMask bit0: check Out / Zero / SC_out against the literals
    //   litMask bit1: check Flags_q against litFlags
    logic [1:0] litMask  = 2'b00;
    logic [7:0] litOut   = 8'h00;
    logic       litZero  = 1'b0;
    logic       litSc    = 1'b0;
    logic [1:0] litFlags = 2'b00;

    logic [1:0] expFlags   = 2'b00;
    logic       flagsKnown = 1'b0;
    logic [9:0] edgeModel;
    logic [9:0] nowModel;

    alu dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .InputA  (InputA),
        .InputB  (InputB),
        .SC_in   (SC_in),
        .OP      (OP),
        .Out     (Out),
        .Zero    (Zero),
        .SC_out  (SC_out),
        .Flags_q (Flags_q)
    );

    always #5 Clk = ~Clk;

    // Reference model, built from the operation definitions.
    // Returned word layout: {zero, carry, out[7:0]}.
    function automatic logic [9:0] refAlu(input int a, input int b, input int c, input int op);
        int r;
        int co;
        r  = 0;
        co = 0;
        case (op)
            0: begin
                r  = a + b + c;
                co = (r > 255) ? 1 : 0;
                r  = r % 256;
            end
            1: begin
                r  = (a * 2 + c) % 256;
                co = a / 128;
            end
            2: begin
                r  = a / 2;
                co = a % 2;
            end
            3: r = a ^ b;
            4: r = a & b;
            5: begin
                r  = (a - b + 256) % 256;
                co = (a < b) ? 1 : 0;
            end
            6: r = a | b;
            default: r = $countones(a) % 2;
        endcase
        return {((r == 0) ? 1'b1 : 1'b0), co[0], r[7:0]};
    endfunction

    // Expected flag register.
    // On each rising edge this records what the DUT should capture from the
    // inputs present at that edge.
    always @(posedge Clk) begin
        edgeModel = refAlu(int'(InputA), int'(InputB), int'(SC_in), int'(OP));
`ifdef ALU_FLAG_REG_EN
        if (Reset) expFlags <= 2'b00;
        else       expFlags <= {edgeModel[8], edgeModel[9]};
`else
        expFlags <= 2'b00;
`endif
        flagsKnown <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h (A=%h B=%h SC_in=%b OP=%b)",
                     name, $time, act, exp, InputA, InputB, SC_in, OP);
        end
    endtask

    // Single compare process, run on the falling edge away from the active edge.
    always @(negedge Clk) begin
        nowModel = refAlu(int'(InputA), int'(InputB), int'(SC_in), int'(OP));
        checkOutput("out",    Out,           nowModel[7:0]);
        checkOutput("zero",   {7'b0, Zero},   {7'b0, nowModel[9]});
        checkOutput("sc_out", {7'b0, SC_out}, {7'b0, nowModel[8]});
        if (flagsKnown)
            checkOutput("flags_q", {6'b0, Flags_q}, {6'b0, expFlags});
        if (litMask[0]) begin
            checkOutput("lit_out",    Out,           litOut);
            checkOutput("lit_zero",   {7'b0, Zero},   {7'b0, litZero});
            checkOutput("lit_sc_out", {7'b0, SC_out}, {7'b0, litSc});
        end
        if (litMask[1])
            checkOutput("lit_flags_q", {6'b0, Flags_q}, {6'b0, litFlags});
    end

    // Drives one stimulus a little after a rising edge. It is checked at the
    // next falling edge and sampled into Flags_q at the following rising edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sc,
                                 input logic [2:0] op, input logic rst, input logic [1:0] mask,
                                 input logic [7:0] lOut, input logic lZero, input logic lSc,
                                 input logic [1:0] lFlags);
        @(posedge Clk);
        #2;
        InputA   = a;
        InputB   = b;
        SC_in    = sc;
        OP       = op;
        Reset    = rst;
        litMask  = mask;
        litOut   = lOut;
        litZero  = lZero;
        litSc    = lSc;
        litFlags = lFlags;
    endtask

    localparam logic [1:0] FLAGS_AFTER_FF01 =
`ifdef ALU_FLAG_REG_EN
        2'b11;
`else
        2'b00;
`endif

    initial begin
        Reset  = 1'b1;
        InputA = 8'h00;
        InputB = 8'h00;
        SC_in  = 1'b0;
        OP     = 3'b000;
        repeat (2) @(posedge Clk);

        // Directed cases with hand-computed results.
        // Arguments: A, B, SC_in, OP, Reset, mask, Out, Zero, SC_out, Flags_q.
        applyStimulus(8'h01, 8'h01, 1'b0, 3'b000, 1'b0, 2'b01, 8'h02, 1'b0, 1'b0, 2'b00);
        applyStimulus(8'hFF, 8'h01, 1'b0, 3'b000, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 2'b00);
        applyStimulus(8'h08, 8'h00, 1'b0, 3'b001, 1'b0, 2'b01, 8'h10, 1'b0, 1'b0, 2'b00);
        applyStimulus(8'h08, 8'h00, 1'b0, 3'b010, 1'b0, 2'b01, 8'h04, 1'b0, 1'b0, 2'b00);
        applyStimulus(8'h81, 8'h00, 1'b1, 3'b001, 1'b0, 2'b01, 8'h03, 1'b0, 1'b1, 2'b00);
        applyStimulus(8'h0F, 8'hF0, 1'b0, 3'b011, 1'b0, 2'b01, 8'hFF, 1'b0, 1'b0, 2'b00);
        applyStimulus(8'h0F, 8'hF0, 1'b0, 3'b100, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 2'b00);
        applyStimulus(8'h0F, 8'hF0, 1'b0, 3'b110, 1'b0, 2'b01, 8'hFF, 1'b0, 1'b0, 2'b00);
        applyStimulus(8'h04, 8'h01, 1'b0, 3'b100, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 2'b00);
        applyStimulus(8'h04, 8'h01, 1'b1, 3'b101, 1'b0, 2'b01, 8'h03, 1'b0, 1'b0, 2'b00);
        applyStimulus(8'h01, 8'h04, 1'b0, 3'b101, 1'b0, 2'b01, 8'hFD, 1'b0, 1'b1, 2'b00);
        applyStimulus(8'h00, 8'h01, 1'b0, 3'b101, 1'b0, 2'b01, 8'hFF, 1'b0, 1'b1, 2'b00);
        applyStimulus(8'h01, 8'h55, 1'b1, 3'b111, 1'b0, 2'b01, 8'h01, 1'b0, 1'b0, 2'b00);
        applyStimulus(8'h03, 8'h00, 1'b0, 3'b111, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 2'b00);
        applyStimulus(8'h01, 8'hAA, 1'b1, 3'b010, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 2'b00);

        // Flag capture, then a one-edge Reset that leaves Out unchanged.
        applyStimulus(8'hFF, 8'h01, 1'b0, 3'b000, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 2'b00);
        applyStimulus(8'hFF, 8'h01, 1'b0, 3'b000, 1'b1, 2'b11, 8'h00, 1'b1, 1'b1, FLAGS_AFTER_FF01);
        applyStimulus(8'hFF, 8'h01, 1'b0, 3'b000, 1'b0, 2'b11, 8'h00, 1'b1, 1'b1, 2'b00);
        applyStimulus(8'hFF, 8'h01, 1'b0, 3'b000, 1'b0, 2'b11, 8'h00, 1'b1, 1'b1, FLAGS_AFTER_FF01);

        // Randomized operands, opcodes and occasional resets, all checked
        // against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
                          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                          2'b00, 8'h00, 1'b0, 1'b0, 2'b00);
        end

        @(posedge Clk);
        @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have: Clk  input  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL have: Reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have: InputA  input  8  operand A.
REQ-004 The block SHALL have: InputB  input  8  operand B.
REQ-005 The block SHALL have: SC_in  input  1  shift/carry in.
REQ-006 The block SHALL have: OP  input  3  operation select.
REQ-007 The block SHALL have: Out  output  8  result, combinational.
REQ-008 The block SHALL have: Zero  output  1  1 when Out == 8'h00, combinational.
REQ-009 The block SHALL have: SC_out  output  1  carry/borrow/shifted-out bit, combinational.
REQ-010 The block SHALL have: Flags_q  output  2  registered {SC_out, Zero} from the previous cycle (bit1 = carry, bit0 = zero).

Function
REQ-011 Out, Zero and SC_out SHALL be purely combinational from InputA/InputB/SC_in/OP; zero-cycle latency, valid within 1 ns of an input change, independent of Clk and Reset.
REQ-012 OP 000 ADD: Out = (A + B + SC_in) mod 256; SC_out = bit 8 of the 9-bit sum.
REQ-013 OP 001 LSH: Out = {A[6:0], SC_in}; SC_out = A[7]; InputB ignored.
REQ-014 OP 010 RSH: Out = {1'b0, A[7:1]}; SC_out = A[0]; SC_in and InputB ignored.
REQ-015 OP 011 XOR: Out = A ^ B; SC_out = 0.
REQ-016 OP 100 AND: Out = A & B; SC_out = 0.
REQ-017 OP 101 SUB: Out = (A - B) mod 256, SC_in ignored; SC_out = 1 when A < B unsigned (borrow), else 0.
REQ-018 OP 110 OR: Out = A | B; SC_out = 0.
REQ-019 OP 111 RXR: Out = {7'b0, ^A} (reduction XOR of A); SC_out = 0; InputB ignored.
REQ-020 All arithmetic SHALL be unsigned 8-bit with wrap-around (e.g. 8'hFF + 8'h01 = 8'h00, SC_out = 1; 8'h00 - 8'h01 = 8'hFF, SC_out = 1).
REQ-021 Zero SHALL be derived from the final Out for every op, including RXR and shifts.
REQ-022 Out SHALL never be X/Z for any 2-state input combination.

Reset
REQ-023 On a rising Clk with Reset = 1, Flags_q SHALL become 2'b00; otherwise it SHALL capture {SC_out, Zero}.
REQ-024 Reset SHALL NOT affect Out, Zero or SC_out; asserting Reset mid-operation only clears Flags_q at that edge.
REQ-025 Reset asserted on the same edge as a flag update SHALL win (Flags_q = 2'b00).

Configuration
REQ-026 Macro ALU_FLAG_REG_EN: when defined, Flags_q SHALL behave per REQ-023..025; when undefined, no flip-flops SHALL be instantiated and Flags_q SHALL be tied to 2'b00, with Out/Zero/SC_out unchanged.

Verification
REQ-027 A=1, B=1, SC_in=0, OP=000 -> Out=8'h02, Zero=0, SC_out=0; A=8'hFF, B=1 -> Out=8'h00, Zero=1, SC_out=1.
REQ-028 A=8'h08, SC_in=0: OP=001 -> Out=8'h10; OP=010 -> Out=8'h04; A=8'h81, OP=001, SC_in=1 -> Out=8'h03, SC_out=1.
REQ-029 A=8'h0F, B=8'hF0: OP=011 -> 8'hFF; OP=100 -> 8'h00 with Zero=1; OP=110 -> 8'hFF; A=4, B=1, OP=100 -> 8'h00.
REQ-030 A=4, B=1, OP=101 -> Out=8'h03, SC_out=0; A=1, B=4 -> Out=8'hFD, SC_out=1.
REQ-031 OP=111: A=8'h01 -> Out=8'h01; A=8'h03 -> Out=8'h00, Zero=1.
REQ-032 With ALU_FLAG_REG_EN: ADD FF+01 then one Clk edge -> Flags_q=2'b11; assert Reset for one edge -> Flags_q=2'b00 while Out stays 8'h00.
